// File: rtl/rca_2bit_pkg.sv
// Shared constants for the ripple-carry adder: default operand width and stage count.
// A WIDTH-sized sum vector type is provided for code working at the default width.
package rca_2bit_pkg;

  localparam int WIDTH_DEFAULT = 2;
  localparam int NUM_STAGES    = WIDTH_DEFAULT;

  typedef logic [WIDTH_DEFAULT-1:0] sum_t;

endpackage : rca_2bit_pkg

// File: rtl/rca_2bit_full_adder.sv
// One-bit full adder, a single stage of the ripple chain.
// Purely combinational; no clock, no reset.
module full_adder
  import rca_2bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  always_comb begin
    p  = a ^ b;
    s  = p ^ ci;
    co = (a & b) | (ci & p);
  end

endmodule : full_adder

// File: rtl/rca_2bit.sv
// Ripple-carry adder with combinational S/Cout and a one-cycle registered copy plus
// signed overflow; registered outputs clear asynchronously while rst is high.
module rca_2bit
  import rca_2bit_pkg::*;
#(
  parameter int WIDTH   = NUM_STAGES,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] S_q,
  output logic             Cout_q,
  output logic             Ovf_q
);

  // c[i] is the carry into stage i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0] c;

  assign c[0] = Cin;
  assign Cout = c[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

  logic ovf_d;
  logic ovf_q;

  always_comb begin
    ovf_d = c[WIDTH-1] ^ c[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf_q = ovf_q;

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    always_comb begin
      sum_d  = S;
      cout_d = Cout;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    assign S_q    = sum_q;
    assign Cout_q = cout_q;
  end else begin : g_no_reg_out
    assign S_q    = '0;
    assign Cout_q = 1'b0;
  end

endmodule : rca_2bit

// File: tb/tb_rca_2bit.sv
// Directed self-checking bench for rca_2bit at the default 2-bit width.
module tb_rca_2bit;
  import rca_2bit_pkg::*;

  logic       clk;
  logic       rst;
  sum_t       a_in;
  sum_t       b_in;
  logic       cin;
  sum_t       s;
  logic       cout;
  sum_t       s_q;
  logic       cout_q;
  logic       ovf_q;

  int checks;
  int errors;

  rca_2bit dut (
    .clk    (clk),
    .rst    (rst),
    .A      (a_in),
    .B      (b_in),
    .Cin    (cin),
    .S      (s),
    .Cout   (cout),
    .S_q    (s_q),
    .Cout_q (cout_q),
    .Ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic ci);
    a_in = a;
    b_in = b;
    cin  = ci;
  endtask

  task automatic check_regs(input string tag, input logic [1:0] es, input logic ec,
                            input logic eo);
    check({tag, ".S_q"},    32'(s_q),    32'(es));
    check({tag, ".Cout_q"}, 32'(cout_q), 32'(ec));
    check({tag, ".Ovf_q"},  32'(ovf_q),  32'(eo));
  endtask

  initial begin
    logic [2:0] iv;
    logic [1:0] jv;
    logic [2:0] exp3;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(2'b00, 2'b00, 1'b0);
    #1;
    check_regs("reset", 2'd0, 1'b0, 1'b0);

    // Combinational sweep while rst is held: sum must ignore reset entirely.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        iv = 3'(i);
        jv = 2'(j);
        drive(iv[1:0], jv, iv[2]);
        #1;
        exp3 = 3'(iv[1:0]) + 3'(jv) + 3'(iv[2]);
        check($sformatf("sweep_a%0d_b%0d_c%0d", iv[1:0], jv, iv[2]),
              32'({cout, s}), 32'(exp3));
        #9;
      end
    end
    check_regs("reset_after_sweep", 2'd0, 1'b0, 1'b0);

    drive(2'b00, 2'b00, 1'b0); #1;
    check("zero_sum", 32'({cout, s}), 32'(3'b000));
    drive(2'b11, 2'b11, 1'b1); #1;
    check("ones_sum", 32'({cout, s}), 32'(3'b111));
    drive(2'b11, 2'b01, 1'b0); #1;
    check("3p1c0", 32'({cout, s}), 32'(3'b100));
    drive(2'b11, 2'b01, 1'b1); #1;
    check("3p1c1", 32'({cout, s}), 32'(3'b101));
    drive(2'b10, 2'b01, 1'b1); #1;
    check("2p1c1_ripple", 32'({cout, s}), 32'(3'b100));

    // First capture after release: 1+2 appears on S_q only after the edge.
    @(negedge clk);
    rst = 1'b0;
    drive(2'b01, 2'b10, 1'b0);
    #1;
    check_regs("pre_edge", 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_regs("cap_1p2", 2'd3, 1'b0, 1'b0);

    // Mid-cycle input change reaches S at once but not S_q.
    drive(2'b11, 2'b11, 1'b0);
    #1;
    check("midcycle_S", 32'({cout, s}), 32'(3'b110));
    check_regs("midcycle_hold", 2'd3, 1'b0, 1'b0);

    @(posedge clk); #1;
    check_regs("cap_3p3", 2'd2, 1'b1, 1'b0);

    drive(2'b01, 2'b01, 1'b0);
    @(posedge clk); #1;
    check_regs("cap_1p1_ovf", 2'd2, 1'b0, 1'b1);

    // Asynchronous reset between edges while registers hold nonzero data.
    #2;
    rst = 1'b1;
    #1;
    check_regs("async_rst", 2'd0, 1'b0, 1'b0);
    check("async_rst_S", 32'({cout, s}), 32'(3'b010));

    drive(2'b11, 2'b11, 1'b1);
    @(posedge clk); #1;
    check_regs("rst_held_edge", 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_regs("post_rst_pre_edge", 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_regs("cap_ones", 2'd3, 1'b1, 1'b0);

    drive(2'b00, 2'b00, 1'b0);
    @(posedge clk); #1;
    check_regs("cap_zero", 2'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rca_2bit

// File: doc/rca_2bit.md
RCA_2BIT -- requirements
Module: rca_2bit

Interface
REQ-001 Parameter: WIDTH, default 2, adder operand width in bits; legal range 1..32.
REQ-002 Parameter: REG_OUT, default 1, 1 = registered outputs S_q/Cout_q present and updated; 0 = S_q/Cout_q tied to 0.
REQ-003 Port: clk  input  1  single system clock; all registers update on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: A  input  WIDTH  operand A, unsigned.
REQ-006 Port: B  input  WIDTH  operand B, unsigned.
REQ-007 Port: Cin  input  1  carry-in.
REQ-008 Port: S  output  WIDTH  combinational sum, A+B+Cin modulo 2^WIDTH.
REQ-009 Port: Cout  output  1  combinational carry-out, bit WIDTH of A+B+Cin.
REQ-010 Port: S_q  output  WIDTH  S registered one clk cycle later.
REQ-011 Port: Cout_q  output  1  Cout registered one clk cycle later.
REQ-012 Port: Ovf_q  output  1  registered signed overflow, carry into MSB XOR carry out of MSB.

Function
REQ-013 {Cout,S} SHALL equal A+B+Cin exactly for all 2^(2*WIDTH+1) input combinations.
REQ-014 S/Cout SHALL be purely combinational: zero-cycle latency, independent of clk and rst.
REQ-015 Sum SHALL be formed as a ripple chain: stage i takes A[i], B[i] and carry c[i]; c[0]=Cin; c[WIDTH]=Cout.
REQ-016 Each stage: sum = a^b^ci; co = (a&b)|(ci&(a^b)).
REQ-017 No carry-lookahead, no `+` operator on the full vector; the ripple structure is the function.
REQ-018 S_q/Cout_q/Ovf_q SHALL capture S/Cout/overflow on each rising clk edge: latency exactly 1 cycle.
REQ-019 Registered outputs SHALL have no enable; they track inputs every cycle.
REQ-020 Boundary: A=B=all-ones, Cin=1 -> S=all-ones, Cout=1; A=B=0, Cin=0 -> S=0, Cout=0.
REQ-021 Inputs changing between clk edges SHALL affect only S/Cout, never registered outputs before the next edge.

Reset
REQ-022 While rst=1, S_q=0, Cout_q=0 and Ovf_q=0 immediately, without waiting for clk.
REQ-023 Reset asserted mid-operation SHALL override any pending capture; the first capture after deassertion occurs on the first rising clk edge with rst=0.
REQ-024 rst SHALL NOT affect combinational S/Cout.

Structure
REQ-025 Shared package: default WIDTH constant and stage-count localparam; no typedefs beyond a WIDTH-sized sum vector type.
REQ-026 One sub-module, full_adder (a, b, ci -> s, co), instantiated WIDTH times via a generate loop.
REQ-027 Output register block SHALL reside in rca_2bit, not in full_adder.

Verification
REQ-028 Exhaustive sweep, WIDTH=2: for i=0..7 and j=0..3, drive A=i[1:0], B=j[1:0], Cin=i[2], hold 10 ns each -> {Cout,S} = A+B+Cin every step (32 vectors).
REQ-029 A=2'b11, B=2'b01, Cin=0 -> S=2'b00, Cout=1; with Cin=1 -> S=2'b01, Cout=1.
REQ-030 A=2'b10, B=2'b01, Cin=1 -> S=2'b00, Cout=1 (full ripple through both stages).
REQ-031 Drive A=1, B=2, Cin=0, apply one clk edge -> S_q=3, Cout_q=0 one cycle later, not before.
REQ-032 Assert rst between clk edges while S_q is nonzero -> S_q, Cout_q, Ovf_q read 0 at once; S still shows A+B+Cin.
REQ-033 A=2'b01, B=2'b01, Cin=0, clock once -> Ovf_q=1, Cout_q=0; A=2'b11, B=2'b11 -> Ovf_q=0, Cout_q=1.
